// File: rtl/step_decoder_pkg.sv
// Shared types and default timing constants for the step/dir receive decoder.
`timescale 1ns/1ps
package step_decoder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StRun,
    StStall
  } state_e;

  localparam int unsigned DefPerW      = 17;
  localparam int unsigned DefMinPeriod = 1000;
  localparam int unsigned DefStallCyc  = 16667;
  localparam int unsigned DefDirSetup  = 10;

endpackage

// File: rtl/sync_ff.sv
// Two-flop synchroniser with synchronous active-low reset.
`timescale 1ns/1ps
module sync_ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/step_decoder.sv
// Step/dir receive decoder: position count, step period measurement and protocol fault flags.
`timescale 1ns/1ps
module step_decoder
  import step_decoder_pkg::*;
#(
  parameter int unsigned POS_W      = 32,
  parameter int unsigned PER_W      = DefPerW,
  parameter int unsigned MIN_PERIOD = DefMinPeriod,
  parameter int unsigned STALL_CYC  = DefStallCyc,
  parameter int unsigned DIR_SETUP  = DefDirSetup
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             drv_step,
  input  logic             drv_dir,
  input  logic             drv_enable_SM,
  input  logic             clr_pos,
  input  logic             clr_err,
  output logic [POS_W-1:0] position,
  output logic [PER_W-1:0] period,
  output logic             period_valid,
  output logic             stall,
  output logic             freq_fault,
  output logic             dir_fault,
  output logic             dis_fault
);

  localparam int unsigned DirW = $clog2(DIR_SETUP + 1);

  localparam logic [POS_W-1:0] PosOne   = {{(POS_W-1){1'b0}}, 1'b1};
  localparam logic [PER_W-1:0] CntOne   = {{(PER_W-1){1'b0}}, 1'b1};
  localparam logic [PER_W-1:0] CntMax   = '1;
  localparam logic [PER_W-1:0] MinPerV  = MIN_PERIOD[PER_W-1:0];
  localparam logic [PER_W-1:0] StallV   = STALL_CYC[PER_W-1:0];
  localparam logic [DirW-1:0]  DirOne   = {{(DirW-1){1'b0}}, 1'b1};
  localparam logic [DirW-1:0]  DirSetV  = DIR_SETUP[DirW-1:0];

  logic step_s, step_q;
  logic dir_s, dir_q;
  logic en_q;
  logic [DirW-1:0]  dir_cnt_q;
  logic [PER_W-1:0] cnt_q;
  state_e           state_q;

  logic             rise;
  logic             counted;
  logic             dir_ok;
  logic             freq_set;
  logic             dir_set;
  logic             dis_set;
  logic [POS_W-1:0] pos_base;
  logic [POS_W-1:0] pos_next;

  sync_ff u_sync_step (
    .clk (clk),
    .rst (rst),
    .d   (drv_step),
    .q   (step_s)
  );

  sync_ff u_sync_dir (
    .clk (clk),
    .rst (rst),
    .d   (drv_dir),
    .q   (dir_s)
  );

  always_comb begin
    rise     = step_s & ~step_q;
    counted  = rise && (state_q != StIdle);
    // Dir is stable once unchanged for DIR_SETUP cycles; a change this cycle counts as zero.
    dir_ok   = (dir_s == dir_q) && (dir_cnt_q >= DirSetV);
    freq_set = rise && (state_q == StRun) && (cnt_q < MinPerV);
    dir_set  = counted && !dir_ok;
    dis_set  = rise && (state_q == StIdle);
    pos_base = clr_pos ? '0 : position;
    pos_next = pos_base;
    if (counted) begin
      pos_next = pos_base + (dir_s ? PosOne : '1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      step_q       <= 1'b0;
      dir_q        <= 1'b0;
      en_q         <= 1'b0;
      dir_cnt_q    <= '0;
      cnt_q        <= '0;
      state_q      <= StIdle;
      position     <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      stall        <= 1'b0;
      freq_fault   <= 1'b0;
      dir_fault    <= 1'b0;
      dis_fault    <= 1'b0;
    end else begin
      step_q       <= step_s;
      dir_q        <= dir_s;
      en_q         <= drv_enable_SM;
      period_valid <= 1'b0;
      position     <= pos_next;

      if (dir_s != dir_q) begin
        dir_cnt_q <= DirOne;
      end else if (dir_cnt_q < DirSetV) begin
        dir_cnt_q <= dir_cnt_q + DirOne;
      end

      // A fault raised in the same cycle as clr_err survives.
      freq_fault <= (freq_fault & ~clr_err) | freq_set;
      dir_fault  <= (dir_fault & ~clr_err) | dir_set;
      dis_fault  <= (dis_fault & ~clr_err) | dis_set;

      case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (en_q) begin
            state_q <= StArmed;
          end
        end
        StArmed: begin
          if (rise) begin
            cnt_q   <= CntOne;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (rise) begin
            period       <= cnt_q;
            period_valid <= 1'b1;
            cnt_q        <= CntOne;
          end else begin
            if (cnt_q != CntMax) begin
              cnt_q <= cnt_q + CntOne;
            end
            if (cnt_q == StallV) begin
              state_q <= StStall;
              stall   <= 1'b1;
            end
          end
        end
        StStall: begin
          if (rise) begin
            cnt_q   <= CntOne;
            state_q <= StRun;
            stall   <= 1'b0;
          end else if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase

      // Dropping enable overrides the state update, but a rise this cycle was already counted.
      if (!en_q && (state_q != StIdle)) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        stall   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_step_decoder.sv
// Self-checking bench: directed scenarios plus random traffic against a time-difference model.
`timescale 1ns/1ps
module tb_step_decoder;

  localparam int MinPer   = 1000;
  localparam int StallCyc = 16667;
  localparam int DirSetup = 10;

  logic        clk = 1'b0;
  logic        rst, drv_step, drv_dir, drv_enable_SM, clr_pos, clr_err;
  logic [31:0] position;
  logic [16:0] period;
  logic        period_valid, stall, freq_fault, dir_fault, dis_fault;

  always #10 clk = ~clk;

  step_decoder u_dut (
    .clk           (clk),
    .rst           (rst),
    .drv_step      (drv_step),
    .drv_dir       (drv_dir),
    .drv_enable_SM (drv_enable_SM),
    .clr_pos       (clr_pos),
    .clr_err       (clr_err),
    .position      (position),
    .period        (period),
    .period_valid  (period_valid),
    .stall         (stall),
    .freq_fault    (freq_fault),
    .dir_fault     (dir_fault),
    .dis_fault     (dis_fault)
  );

  int checks = 0;
  int passes = 0;
  int cyc_fail_prints = 0;
  int pv_seen = 0;

  // Model: raw input history (index 0 = sample at this edge), mode 0..3 = idle/armed/run/stall.
  int          m_edge = 0;
  int          mode = 0;
  int          last_step = 0;
  int          last_chg = 0;
  logic [3:0]  h_st = '0;
  logic [3:0]  h_dr = '0;
  logic [1:0]  h_en = '0;
  logic [31:0] m_pos = '0;
  logic [16:0] m_per = '0;
  logic        m_pv = 0, m_stall = 0, m_ff = 0, m_df = 0, m_dis = 0;

  task automatic model_step();
    bit evt, cnt_ev, fset, dset, sset;
    int stab, nmode, gap;
    m_edge++;
    if (!rst) begin
      mode = 0; h_st = '0; h_dr = '0; h_en = '0; last_chg = m_edge;
      m_pos = '0; m_per = '0; m_pv = 0; m_stall = 0; m_ff = 0; m_df = 0; m_dis = 0;
      return;
    end
    h_st = {h_st[2:0], drv_step};
    h_dr = {h_dr[2:0], drv_dir};
    h_en = {h_en[0], drv_enable_SM};
    // The decoder acts on the step/dir sample from two edges ago and enable from one edge ago.
    evt = h_st[2] && !h_st[3];
    if (h_dr[2] != h_dr[3]) last_chg = m_edge - 2;
    stab = m_edge - 2 - last_chg;
    gap = m_edge - last_step;
    cnt_ev = 0; fset = 0; sset = 0; m_pv = 0;
    nmode = mode;
    case (mode)
      0: begin
        if (evt) sset = 1;
        if (h_en[1]) nmode = 1;
      end
      1: if (evt) begin cnt_ev = 1; nmode = 2; last_step = m_edge; end
      2: begin
        if (evt) begin
          m_per = 17'(gap); m_pv = 1; fset = (gap < MinPer);
          cnt_ev = 1; last_step = m_edge;
        end else if (gap >= StallCyc) begin
          nmode = 3;
        end
      end
      default: if (evt) begin cnt_ev = 1; nmode = 2; last_step = m_edge; end
    endcase
    if (mode != 0 && !h_en[1]) nmode = 0;
    mode = nmode;
    m_stall = (mode == 3);
    dset = cnt_ev && (stab < DirSetup);
    if (clr_pos) m_pos = '0;
    if (cnt_ev) m_pos = h_dr[2] ? m_pos + 32'd1 : m_pos - 32'd1;
    m_ff  = (m_ff & ~clr_err) | fset;
    m_df  = (m_df & ~clr_err) | dset;
    m_dis = (m_dis & ~clr_err) | sset;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic tick();
    logic [53:0] dut_v, mod_v;
    @(posedge clk);
    #1;
    model_step();
    dut_v = {position, period, period_valid, stall, freq_fault, dir_fault, dis_fault};
    mod_v = {m_pos, m_per, m_pv, m_stall, m_ff, m_df, m_dis};
    checks++;
    if (dut_v === mod_v) passes++;
    else if (cyc_fail_prints < 20) begin
      cyc_fail_prints++;
      $display("FAIL cycle %0d outputs: actual %0h required %0h", m_edge, dut_v, mod_v);
    end
    if (period_valid) pv_seen++;
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Step rises now; next rise may follow `gap` cycles later. Clears land on the edge the step counts.
  task automatic do_step(input int gap, input bit cp, input bit ce);
    for (int i = 0; i < gap; i++) begin
      drv_step = (i < 4);
      clr_pos  = cp && (i == 2);
      clr_err  = ce && (i == 2);
      tick();
    end
    drv_step = 1'b0; clr_pos = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    int next_gap, hold;
    rst = 1'b0; drv_step = 1'b0; drv_dir = 1'b1; drv_enable_SM = 1'b0;
    clr_pos = 1'b0; clr_err = 1'b0;

    for (int i = 0; i < 3; i++) begin
      drv_step = ~drv_step;
      tick();
    end
    drv_step = 1'b0;
    check("reset_outputs", {position, period, period_valid, stall, freq_fault, dir_fault,
                            dis_fault}, 64'd0);

    rst = 1'b1; drv_enable_SM = 1'b1;
    wait_n(20);
    pv_seen = 0;
    for (int i = 0; i < 5; i++) do_step(2000, 1'b0, 1'b0);
    check("nominal_position", position, 64'd5);
    check("nominal_pv_count", pv_seen, 64'd4);
    check("nominal_period", period, 64'd2000);
    check("nominal_faults", {freq_fault, dir_fault, dis_fault, stall}, 64'd0);

    do_step(800, 1'b0, 1'b0);
    do_step(400, 1'b0, 1'b0);
    check("overspeed_period", period, 64'd800);
    check("overspeed_fault", freq_fault, 64'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_err_clears", freq_fault, 64'd0);
    wait_n(399);
    do_step(2000, 1'b0, 1'b1);
    check("clr_err_loses_to_set", freq_fault, 64'd1);

    wait_n(15000);
    check("stall_entered", stall, 64'd1);
    pv_seen = 0;
    do_step(2000, 1'b0, 1'b0);
    check("stall_exit", stall, 64'd0);
    check("stall_exit_no_pv", pv_seen, 64'd0);
    check("stall_exit_position", position, 64'd9);
    do_step(2000, 1'b0, 1'b0);
    check("post_stall_period", period, 64'd2000);

    clr_pos = 1'b1;
    tick();
    clr_pos = 1'b0;
    drv_dir = 1'b0;
    wait_n(5);
    do_step(2000, 1'b0, 1'b0);
    check("dir_wrap_position", position, 64'hFFFF_FFFF);
    check("dir_setup_fault", dir_fault, 64'd1);

    drv_enable_SM = 1'b0;
    wait_n(10);
    for (int i = 0; i < 3; i++) do_step(100, 1'b0, 1'b0);
    check("disabled_fault", dis_fault, 64'd1);
    check("disabled_position", position, 64'hFFFF_FFFF);
    drv_enable_SM = 1'b1; drv_dir = 1'b1;
    wait_n(50);
    do_step(2000, 1'b1, 1'b0);
    check("clr_pos_with_step", position, 64'd1);

    next_gap = 50; hold = 0;
    for (int i = 0; i < 30000; i++) begin
      rst = !(i >= 15000 && i < 15003);
      if (next_gap == 0) begin
        hold = 3;
        next_gap = ($urandom_range(0, 11) == 0) ? $urandom_range(16000, 17500)
                                                : $urandom_range(300, 2600);
      end else begin
        next_gap--;
      end
      drv_step = (hold > 0);
      if (hold > 0) hold--;
      if ($urandom_range(0, 149) == 0) drv_dir = ~drv_dir;
      if (drv_enable_SM && $urandom_range(0, 3999) == 0) drv_enable_SM = 1'b0;
      else if (!drv_enable_SM && $urandom_range(0, 299) == 0) drv_enable_SM = 1'b1;
      clr_pos = ($urandom_range(0, 999) == 0);
      clr_err = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/step_decoder.md
# step_decoder

Receive-side decoder for the stepper step/dir interface (`drv_step`, `drv_dir`, `drv_enable_SM`) generated by the tracking and pulse-generator blocks. It synchronises the step and dir lines and keeps a signed absolute position count. It measures the clk-cycle period between consecutive step edges and flags protocol violations: over-speed, dir setup violation, steps while disabled, and stall. It sits beside the motor-driver outputs as a closed-loop monitor and bench checker.

## Interface

Parameters:
- `POS_W`, 32: position counter width (signed, two's complement)
- `PER_W`, 17: period width; matches the period bus `N`
- `MIN_PERIOD`, 1000: shortest legal step period in clk cycles (50 kHz at 50 MHz)
- `STALL_CYC`, 16667: cycles without a step edge before stall (2 × 6 kHz period)
- `DIR_SETUP`, 10: minimum cycles `drv_dir` must be stable before a step rising edge

Ports:
- `clk`, in, 1: 50 MHz system clock
- `rst`, in, 1: synchronous, active-low reset
- `drv_step`, in, 1: step pulse; each rising edge is one step
- `drv_dir`, in, 1: direction; 1 = +1, 0 = −1
- `drv_enable_SM`, in, 1: driver enable
- `clr_pos`, in, 1: synchronous position clear
- `clr_err`, in, 1: clears the sticky fault flags
- `position`, out, POS_W: signed step count
- `period`, out, PER_W: last measured step period in clk cycles
- `period_valid`, out, 1: one-cycle strobe when `period` updates
- `stall`, out, 1: level; high while in STALL
- `freq_fault`, out, 1: sticky; a measured period was < MIN_PERIOD
- `dir_fault`, out, 1: sticky; dir setup violated
- `dis_fault`, out, 1: sticky; a step edge occurred while disabled

## Operation

- **Synchronisers:** `drv_step` and `drv_dir` each pass through a 2-flop synchroniser.
- **Step rise:** `rise` = synced step high AND its one-cycle-delayed copy low.
- **`drv_enable_SM`:** used as registered once; no synchroniser.
- **States (reset → IDLE):**
  - IDLE:
    - enable=1 → ARMED.
    - A rise in IDLE sets `dis_fault`; `position` is unchanged.
  - ARMED:
    - On rise: update `position`, set `cnt`=1, go to RUN.
    - No `period_valid` on this first step.
  - RUN:
    - `cnt` increments each cycle and saturates at 2^PER_W−1.
    - On rise: `period`←`cnt`, pulse `period_valid`, set `cnt`=1, update `position`.
    - If `cnt` < MIN_PERIOD at that rise, also set `freq_fault`.
    - When `cnt` reaches STALL_CYC → STALL.
  - STALL:
    - `stall`=1.
    - On rise: update `position`, set `cnt`=1, go to RUN, `stall`→0.
    - No `period_valid`, because the period value is stale.
  - Any state with enable=0 → IDLE next cycle. `cnt` and `stall` are cleared; `position` and `period` are held.
- **Dir setup:**
  - A dir stability counter resets on every change of the synced dir.
  - A rise with that counter < DIR_SETUP sets `dir_fault`.
  - The step is still applied using the new dir.
- **Position arithmetic:** ±1 per step, wrapping modulo 2^POS_W (0 − 1 = all ones).
- **`clr_pos`:**
  - `position`←0.
  - If coincident with a counted rise, `position`←±1, i.e. clear first, then apply the step.
- **`clr_err`:**
  - Clears `freq_fault`, `dir_fault` and `dis_fault`.
  - A fault being set in the same cycle wins, so the flag stays 1.

## Timing

- **Reset values:** all outputs 0, state IDLE, `cnt` 0.
- **Step latency:**
  - `drv_step` first sampled high at edge E0.
  - `position`, `period`, `period_valid` and the faults update at E2 and are visible after E2.
- **Period reference:** `period` counts the cycles between consecutive sampled rising edges. The constant synchroniser delay cancels out.
- **`period_valid`:** high for exactly one cycle per reported period.
- **Stall entry:** `stall` rises the cycle after `cnt` = STALL_CYC.
- **Enable drop:** IDLE is entered 1 cycle after `drv_enable_SM` is sampled low. A rise in that same cycle is still counted.
- **Reset mid-operation:** returns to the reset values on the next edge while `rst`=0.

## Structure

- **Package `step_decoder_pkg`:** state enum (IDLE, ARMED, RUN, STALL), default PER_W, MIN_PERIOD, STALL_CYC and DIR_SETUP values.
- **Sub-module `sync_ff`:** 2-flop synchroniser with synchronous active-low reset, instantiated for step and dir.
- **Top-level logic:** FSM, period counter, dir stability counter, position register and fault flags all live in `step_decoder`.

## Test plan

- **Reset:** hold `rst`=0 for 3 cycles with `drv_step` toggling → all outputs 0; after release, state IDLE.
- **Nominal run:** enable, dir=1, 5 steps every 2000 cycles → `position`=5; 4 `period_valid` strobes each with `period`=2000; no faults.
- **Over-speed:** steps every 800 cycles → `period`=800 and `freq_fault`=1. Then pulse `clr_err` → 0. Then `clr_err` coincident with another 800-cycle step → stays 1.
- **Stall:** no step for 16667 cycles → `stall`=1. Next step → `stall`=0, no `period_valid`, `position`+1. Following step at 2000 cycles → `period`=2000.
- **Dir and wrap:** from `position`=0, dir=0, toggle dir 5 cycles before a step → `dir_fault`=1 and `position`=all ones (−1).
- **Disabled steps and clear:** enable=0 with 3 steps → `dis_fault`=1 and `position` unchanged. Re-enable, then `clr_pos` coincident with a dir=1 counted rise → `position`=1.
